// File: rtl/hsid_x_ctrl_seq.sv
// HSpecID-X job sequencer: programs the control block, starts it, polls
// STATUS and returns the four MSE results over a simple register bus.
module hsid_x_ctrl_seq #(
  parameter int WORD_WIDTH       = 32,
  parameter int HSI_BANDS        = 128,
  parameter int HSI_LIBRARY_SIZE = 256,
  parameter int POLL_GAP         = 8,
  parameter int MAX_POLLS        = 1024,
  localparam int HSI_BANDS_ADDR        = $clog2(HSI_BANDS),
  localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE),
  localparam int STRB_WIDTH            = WORD_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] cmd_library_size,
  input  logic [HSI_BANDS_ADDR-1:0]        cmd_pixel_bands,
  input  logic [WORD_WIDTH-1:0]            cmd_captured_addr,
  input  logic [WORD_WIDTH-1:0]            cmd_library_addr,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [1:0]                       res_status,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] res_min_ref,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] res_max_ref,
  output logic [WORD_WIDTH-1:0]            res_min_value,
  output logic [WORD_WIDTH-1:0]            res_max_value,
  output logic                             reg_valid,
  output logic                             reg_write,
  output logic [WORD_WIDTH-1:0]            reg_addr,
  output logic [WORD_WIDTH-1:0]            reg_wdata,
  output logic [STRB_WIDTH-1:0]            reg_wstrb,
  input  logic                             reg_ready,
  input  logic                             reg_error,
  input  logic [WORD_WIDTH-1:0]            reg_rdata
);

  localparam int PCW = $clog2(MAX_POLLS + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);

  localparam logic [WORD_WIDTH-1:0] A_STATUS = WORD_WIDTH'(32'h00);
  localparam logic [WORD_WIDTH-1:0] A_LIB    = WORD_WIDTH'(32'h04);
  localparam logic [WORD_WIDTH-1:0] A_BANDS  = WORD_WIDTH'(32'h08);
  localparam logic [WORD_WIDTH-1:0] A_CAP    = WORD_WIDTH'(32'h0C);
  localparam logic [WORD_WIDTH-1:0] A_LADDR  = WORD_WIDTH'(32'h10);
  localparam logic [WORD_WIDTH-1:0] A_MINR   = WORD_WIDTH'(32'h14);
  localparam logic [WORD_WIDTH-1:0] A_MINV   = WORD_WIDTH'(32'h18);
  localparam logic [WORD_WIDTH-1:0] A_MAXR   = WORD_WIDTH'(32'h1C);
  localparam logic [WORD_WIDTH-1:0] A_MAXV   = WORD_WIDTH'(32'h20);

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_HW  = 2'd1;
  localparam logic [1:0] ST_BUS = 2'd2;
  localparam logic [1:0] ST_TMO = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_LIB,
    S_WR_BANDS,
    S_WR_CAP,
    S_WR_LADDR,
    S_WR_START,
    S_POLL_RD,
    S_POLL_WAIT,
    S_WR_CLR,
    S_RD_MINR,
    S_RD_MINV,
    S_RD_MAXR,
    S_RD_MAXV,
    S_RESP
  } state_t;

  state_t state;
  state_t state_n;

  logic [HSI_LIBRARY_SIZE_ADDR-1:0] lib_size;
  logic [HSI_BANDS_ADDR-1:0]        bands;
  logic [WORD_WIDTH-1:0]            cap_addr;
  logic [WORD_WIDTH-1:0]            lib_addr;
  logic [PCW-1:0]                   poll_cnt;
  logic [GCW-1:0]                   gap_cnt;

  logic                  xfer;
  logic                  issue;
  logic                  accept;
  logic                  bus_state;
  logic                  poll_last;
  logic                  gap_last;
  logic                  fin;
  logic [1:0]            fin_status;
  logic [WORD_WIDTH-1:0] x_addr;
  logic [WORD_WIDTH-1:0] x_wdata;
  logic                  x_write;

  assign xfer      = reg_valid && reg_ready;
  assign accept    = (state == S_IDLE) && cmd_valid;
  assign poll_last = (poll_cnt == PCW'(MAX_POLLS - 1));
  assign gap_last  = (gap_cnt == GCW'(POLL_GAP - 1));
  assign issue     = bus_state && !reg_valid;
  assign cmd_ready = (state == S_IDLE);
  assign res_valid = (state == S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    bus_state  = 1'b0;
    x_addr     = A_STATUS;
    x_write    = 1'b0;
    x_wdata    = '0;
    fin        = 1'b0;
    fin_status = ST_OK;
    unique case (state)
      S_IDLE: if (cmd_valid) state_n = S_WR_LIB;
      S_WR_LIB: begin
        bus_state = 1'b1;
        x_addr    = A_LIB;
        x_write   = 1'b1;
        x_wdata   = WORD_WIDTH'(lib_size);
        if (xfer) state_n = S_WR_BANDS;
      end
      S_WR_BANDS: begin
        bus_state = 1'b1;
        x_addr    = A_BANDS;
        x_write   = 1'b1;
        x_wdata   = WORD_WIDTH'(bands);
        if (xfer) state_n = S_WR_CAP;
      end
      S_WR_CAP: begin
        bus_state = 1'b1;
        x_addr    = A_CAP;
        x_write   = 1'b1;
        x_wdata   = cap_addr;
        if (xfer) state_n = S_WR_LADDR;
      end
      S_WR_LADDR: begin
        bus_state = 1'b1;
        x_addr    = A_LADDR;
        x_write   = 1'b1;
        x_wdata   = lib_addr;
        if (xfer) state_n = S_WR_START;
      end
      S_WR_START: begin
        bus_state = 1'b1;
        x_write   = 1'b1;
        x_wdata   = WORD_WIDTH'(32'h1);
        if (xfer) state_n = S_POLL_RD;
      end
      S_POLL_RD: begin
        bus_state = 1'b1;
        // done takes priority over error when both are reported
        if (xfer) begin
          if (reg_rdata[4]) begin
            state_n = S_RD_MINR;
          end else if (reg_rdata[5]) begin
            state_n    = S_RESP;
            fin        = 1'b1;
            fin_status = ST_HW;
          end else if (poll_last) begin
            state_n = S_WR_CLR;
          end else begin
            state_n = S_POLL_WAIT;
          end
        end
      end
      S_POLL_WAIT: if (gap_last) state_n = S_POLL_RD;
      S_WR_CLR: begin
        bus_state = 1'b1;
        x_write   = 1'b1;
        x_wdata   = WORD_WIDTH'(32'h2);
        if (xfer) begin
          state_n    = S_RESP;
          fin        = 1'b1;
          fin_status = ST_TMO;
        end
      end
      S_RD_MINR: begin
        bus_state = 1'b1;
        x_addr    = A_MINR;
        if (xfer) state_n = S_RD_MINV;
      end
      S_RD_MINV: begin
        bus_state = 1'b1;
        x_addr    = A_MINV;
        if (xfer) state_n = S_RD_MAXR;
      end
      S_RD_MAXR: begin
        bus_state = 1'b1;
        x_addr    = A_MAXR;
        if (xfer) state_n = S_RD_MAXV;
      end
      S_RD_MAXV: begin
        bus_state = 1'b1;
        x_addr    = A_MAXV;
        if (xfer) begin
          state_n    = S_RESP;
          fin        = 1'b1;
          fin_status = ST_OK;
        end
      end
      S_RESP: if (res_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // a failed transfer anywhere abandons the job without cleanup
    if (xfer && reg_error) begin
      state_n    = S_RESP;
      fin        = 1'b1;
      fin_status = ST_BUS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_valid     <= 1'b0;
      reg_write     <= 1'b0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      reg_wstrb     <= '0;
      lib_size      <= '0;
      bands         <= '0;
      cap_addr      <= '0;
      lib_addr      <= '0;
      poll_cnt      <= '0;
      gap_cnt       <= '0;
      res_status    <= ST_OK;
      res_min_ref   <= '0;
      res_min_value <= '0;
      res_max_ref   <= '0;
      res_max_value <= '0;
    end else begin
      if (issue) begin
        reg_valid <= 1'b1;
        reg_addr  <= x_addr;
        reg_write <= x_write;
        reg_wdata <= x_wdata;
        reg_wstrb <= x_write ? '1 : '0;
      end else if (xfer) begin
        reg_valid <= 1'b0;
      end
      if (accept) begin
        lib_size      <= cmd_library_size;
        bands         <= cmd_pixel_bands;
        cap_addr      <= cmd_captured_addr;
        lib_addr      <= cmd_library_addr;
        poll_cnt      <= '0;
        res_status    <= ST_OK;
        res_min_ref   <= '0;
        res_min_value <= '0;
        res_max_ref   <= '0;
        res_max_value <= '0;
      end
      if (state == S_POLL_RD && xfer) poll_cnt <= poll_cnt + PCW'(1);
      if (state == S_POLL_WAIT) gap_cnt <= gap_cnt + GCW'(1);
      else                      gap_cnt <= '0;
      if (xfer && !reg_error) begin
        if (state == S_RD_MINR)
          res_min_ref <= reg_rdata[HSI_LIBRARY_SIZE_ADDR-1:0];
        if (state == S_RD_MINV) res_min_value <= reg_rdata;
        if (state == S_RD_MAXR)
          res_max_ref <= reg_rdata[HSI_LIBRARY_SIZE_ADDR-1:0];
        if (state == S_RD_MAXV) res_max_value <= reg_rdata;
      end
      if (fin) res_status <= fin_status;
    end
  end

endmodule

// File: tb/tb_hsid_x_ctrl_seq.sv
// Scoreboard bench for hsid_x_ctrl_seq: a job-level model predicts the
// bus transfer list and result; slave and result monitors check them.
module tb_hsid_x_ctrl_seq;
  localparam int PG = 3;
  localparam int MP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_library_size;
  logic [6:0]  cmd_pixel_bands;
  logic [31:0] cmd_captured_addr;
  logic [31:0] cmd_library_addr;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_status;
  logic [7:0]  res_min_ref;
  logic [7:0]  res_max_ref;
  logic [31:0] res_min_value;
  logic [31:0] res_max_value;
  logic        reg_valid;
  logic        reg_write;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ready;
  logic        reg_error;
  logic [31:0] reg_rdata;

  always #5 clk = ~clk;

  hsid_x_ctrl_seq #(
    .WORD_WIDTH(32), .HSI_BANDS(128), .HSI_LIBRARY_SIZE(256),
    .POLL_GAP(PG), .MAX_POLLS(MP)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_library_size(cmd_library_size),
    .cmd_pixel_bands(cmd_pixel_bands),
    .cmd_captured_addr(cmd_captured_addr),
    .cmd_library_addr(cmd_library_addr),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_status(res_status),
    .res_min_ref(res_min_ref), .res_max_ref(res_max_ref),
    .res_min_value(res_min_value), .res_max_value(res_max_value),
    .reg_valid(reg_valid), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ready(reg_ready), .reg_error(reg_error), .reg_rdata(reg_rdata)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    logic [1:0]  st;
    logic [7:0]  minr;
    logic [31:0] minv;
    logic [7:0]  maxr;
    logic [31:0] maxv;
  } res_t;

  xfer_t exp_x[$];
  res_t  exp_r[$];

  int checks = 0;
  int errors = 0;
  int jobs_done = 0;
  int cyc = 0;

  // slave script for the current job
  int s_done, s_err, s_both, s_bus, s_wmax;
  logic [31:0] s_minr, s_minv, s_maxr, s_maxv;
  int sl_idx, sl_poll, last_end;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] status_word(input int k);
    logic [31:0] w;
    w = 32'h4;
    if (k == s_done) w = w | 32'h10 | (s_both != 0 ? 32'h20 : 32'h0);
    else if (k == s_err) w = w | 32'h20;
    return w;
  endfunction

  function automatic logic [31:0] mse_word(input logic [31:0] a);
    case (a)
      32'h14:  return s_minr;
      32'h18:  return s_minv;
      32'h1C:  return s_maxr;
      32'h20:  return s_maxv;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic xfer_t mk(input bit wr, input logic [31:0] a,
                               input logic [31:0] d);
    xfer_t t;
    t.wr = wr; t.addr = a; t.data = d;
    return t;
  endfunction

  // job-level model: the transfer list the job must produce and its result
  task automatic build_expect(input logic [7:0] lib, input logic [6:0] bnd,
                              input logic [31:0] cap, input logic [31:0] la);
    xfer_t l[$];
    res_t r;
    logic [31:0] w;
    int oc, n;
    l.push_back(mk(1, 32'h04, {24'h0, lib}));
    l.push_back(mk(1, 32'h08, {25'h0, bnd}));
    l.push_back(mk(1, 32'h0C, cap));
    l.push_back(mk(1, 32'h10, la));
    l.push_back(mk(1, 32'h00, 32'h1));
    oc = 3;
    for (int k = 1; k <= MP; k++) begin
      l.push_back(mk(0, 32'h00, 32'h0));
      w = status_word(k);
      if (w[4]) begin oc = 0; break; end
      if (w[5]) begin oc = 1; break; end
    end
    if (oc == 3) l.push_back(mk(1, 32'h00, 32'h2));
    if (oc == 0) begin
      l.push_back(mk(0, 32'h14, 32'h0));
      l.push_back(mk(0, 32'h18, 32'h0));
      l.push_back(mk(0, 32'h1C, 32'h0));
      l.push_back(mk(0, 32'h20, 32'h0));
    end
    r.st = 2'(oc);
    r.minr = '0; r.minv = '0; r.maxr = '0; r.maxv = '0;
    n = l.size();
    if (s_bus >= 0 && s_bus < n) begin
      n = s_bus + 1;
      r.st = 2'd2;
    end
    for (int i = 0; i < n; i++) begin
      exp_x.push_back(l[i]);
      if (!l[i].wr && i != s_bus) begin
        w = mse_word(l[i].addr);
        case (l[i].addr)
          32'h14: r.minr = w[7:0];
          32'h18: r.minv = w;
          32'h1C: r.maxr = w[7:0];
          32'h20: r.maxv = w;
          default: ;
        endcase
      end
    end
    exp_r.push_back(r);
  endtask

  // register slave with random wait states; checks each completed transfer
  initial begin
    bit active, stable, prev_hs;
    logic [68:0] snap;
    int wl;
    xfer_t t;
    active = 0; stable = 1; prev_hs = 0; wl = 0; snap = '0;
    reg_ready = 0; reg_error = 0; reg_rdata = '0;
    forever begin
      @(negedge clk);
      reg_ready = 0;
      reg_error = 0;
      if (prev_hs) chk("valid_drop", 64'(reg_valid), 64'd0);
      prev_hs = 0;
      if (rst || !reg_valid) begin
        active = 0;
      end else begin
        if (!active) begin
          active = 1;
          stable = 1;
          wl = $urandom_range(0, s_wmax);
          snap = {reg_write, reg_addr, reg_wdata, reg_wstrb};
          if (!reg_write && reg_addr == 32'h0 && last_end >= 0)
            chk("poll_gap", 64'((cyc - last_end - 1) >= PG), 64'd1);
        end else if ({reg_write, reg_addr, reg_wdata, reg_wstrb} != snap) begin
          stable = 0;
        end
        if (wl == 0) begin
          active = 0;
          prev_hs = 1;
          chk("bus_stable", 64'(stable), 64'd1);
          reg_ready = 1;
          reg_error = (sl_idx == s_bus);
          if (reg_write) reg_rdata = $urandom;
          else if (reg_addr == 32'h0) begin
            sl_poll++;
            reg_rdata = status_word(sl_poll);
            last_end = cyc;
          end else reg_rdata = mse_word(reg_addr);
          sl_idx++;
          if (exp_x.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_extra actual=%0h@%0h required=none",
                     reg_write, reg_addr);
          end else begin
            t = exp_x.pop_front();
            chk("xfer_hdr", {reg_write, reg_addr, reg_wstrb},
                {t.wr, t.addr, (t.wr ? 4'hF : 4'h0)});
            if (t.wr) chk("xfer_wdata", 64'(reg_wdata), 64'(t.data));
          end
        end else begin
          wl--;
        end
      end
    end
  end

  // result monitor: random consumer back-pressure, pops the scoreboard
  initial begin
    res_t r;
    res_ready = 0;
    forever begin
      @(negedge clk);
      res_ready = ($urandom_range(0, 2) != 0);
      if (res_valid && res_ready) begin
        if (exp_r.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_extra actual=%0d required=none", res_status);
        end else begin
          r = exp_r.pop_front();
          chk("res_status", 64'(res_status), 64'(r.st));
          chk("res_min", {res_min_ref, res_min_value}, {r.minr, r.minv});
          chk("res_max", {res_max_ref, res_max_value}, {r.maxr, r.maxv});
        end
        jobs_done++;
      end
    end
  end

  task automatic check_reset();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_reg_ctl", {reg_valid, reg_write, reg_wstrb}, 64'd0);
    chk("rst_reg_addr", 64'(reg_addr), 64'd0);
    chk("rst_reg_wdata", 64'(reg_wdata), 64'd0);
    chk("rst_res_status", 64'(res_status), 64'd0);
    chk("rst_res_min", {res_min_ref, res_min_value}, 64'd0);
    chk("rst_res_max", {res_max_ref, res_max_value}, 64'd0);
  endtask

  task automatic run_job(input logic [7:0] lib, input logic [6:0] bnd,
                         input logic [31:0] cap, input logic [31:0] la,
                         input bit wait_done);
    int start, n;
    sl_idx = 0;
    sl_poll = 0;
    last_end = -1;
    build_expect(lib, bnd, cap, la);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    start = jobs_done;
    cmd_valid = 1;
    cmd_library_size = lib;
    cmd_pixel_bands = bnd;
    cmd_captured_addr = cap;
    cmd_library_addr = la;
    @(negedge clk);
    cmd_valid = 0;
    cmd_library_size = 8'($urandom);
    cmd_pixel_bands = 7'($urandom);
    cmd_captured_addr = $urandom;
    cmd_library_addr = $urandom;
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    if (wait_done) begin
      n = 0;
      while (jobs_done == start && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("job_done", 64'(jobs_done != start), 64'd1);
      @(negedge clk);
      chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
      chk("xfer_left", 64'(exp_x.size()), 64'd0);
    end
  endtask

  task automatic script(input int dn, input int er, input int both,
                        input int bus, input int wmax);
    s_done = dn; s_err = er; s_both = both; s_bus = bus; s_wmax = wmax;
    s_minr = 32'd5; s_minv = 32'h40; s_maxr = 32'd9; s_maxv = 32'h900;
  endtask

  initial begin
    int n;
    rst = 1;
    cmd_valid = 0;
    cmd_library_size = '0;
    cmd_pixel_bands = '0;
    cmd_captured_addr = '0;
    cmd_library_addr = '0;
    script(3, 0, 0, -1, 0);
    sl_idx = 0; sl_poll = 0; last_end = -1;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 0;
    @(negedge clk);

    script(3, 0, 0, -1, 0);
    run_job(8'd16, 7'd64, 32'h1000, 32'h2000, 1);
    script(3, 0, 0, -1, 4);
    run_job(8'd16, 7'd64, 32'h1000, 32'h2000, 1);
    script(0, 1, 0, -1, 2);
    run_job(8'd200, 7'd127, 32'hCAFE_0000, 32'h0BAD_F00D, 1);
    script(0, 0, 0, -1, 2);
    run_job(8'd1, 7'd1, 32'h10, 32'h20, 1);
    script(3, 0, 0, 1, 2);
    run_job(8'd16, 7'd64, 32'h1000, 32'h2000, 1);
    script(2, 0, 1, -1, 1);
    run_job(8'd255, 7'd3, 32'hFFFF_FFFC, 32'h4, 1);

    script(3, 0, 0, -1, 2);
    run_job(8'd16, 7'd64, 32'h1000, 32'h2000, 0);
    n = 0;
    while (sl_poll < 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1;
    #1;
    check_reset();
    exp_x.delete();
    exp_r.delete();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    script(3, 0, 0, -1, 2);
    run_job(8'd16, 7'd64, 32'h1000, 32'h2000, 1);

    for (int j = 0; j < 24; j++) begin
      script($urandom_range(1, 6), $urandom_range(1, 6),
             $urandom_range(0, 1),
             ($urandom_range(0, 2) == 0) ? $urandom_range(0, 13) : -1,
             $urandom_range(0, 4));
      s_minr = $urandom; s_minv = $urandom;
      s_maxr = $urandom; s_maxv = $urandom;
      run_job(8'($urandom), 7'($urandom), $urandom, $urandom, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
